// File: rtl/rf_synth_prog_if.sv
// rf_synth_prog_if: hop request, register and 3-wire radio bus signals
// shared between the hop-selection side (master) and rf_synth_prog (slave).
interface rf_synth_prog_if;
  logic       p_033us;
  logic [6:0] fk;
  logic       fk_chg_p;
  logic       rxmode;
  logic [3:0] regi_IF_offset;
  logic [3:0] regi_synth_addr;
  logic [9:0] regi_settle_time;
  logic       rf_sen_n;
  logic       rf_sclk;
  logic       rf_sdata;
  logic       fkset_p;
  logic       busy;
  logic       fk_err;

  modport master (
    output p_033us, fk, fk_chg_p, rxmode, regi_IF_offset, regi_synth_addr,
           regi_settle_time,
    input  rf_sen_n, rf_sclk, rf_sdata, fkset_p, busy, fk_err
  );

  modport slave (
    input  p_033us, fk, fk_chg_p, rxmode, regi_IF_offset, regi_synth_addr,
           regi_settle_time,
    output rf_sen_n, rf_sclk, rf_sdata, fkset_p, busy, fk_err
  );
endinterface

// File: rtl/rf_synth_prog.sv
// rf_synth_prog: turns a hop channel into a synthesizer frequency word,
// shifts it out MSB first on a 3-wire bus (4 clk_6M cycles per bit), waits
// for PLL settling and pulses fkset_p. Requests arriving mid-frame are held
// pending so a frame on the wire is never cut short.
// Optional feature: define RF_PROG_PARITY_EN to append an odd-parity bit
// (17-bit frame); undefined gives the plain 16-bit frame.
module rf_synth_prog (
  input logic            clk_6M,
  input logic            rstz,
  rf_synth_prog_if.slave bus
);
`ifdef RF_PROG_PARITY_EN
  localparam int FRAME_BITS = 17;
`else
  localparam int FRAME_BITS = 16;
`endif
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SETTLE} state_t;

  state_t                state_reg;
  logic                  pend_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [1:0]            phase_reg;
  logic [4:0]            bit_reg;
  logic [9:0]            tick_reg;
  logic                  sen_n_reg;
  logic                  sclk_reg;
  logic                  sdata_reg;
  logic                  fkset_reg;
  logic                  busy_reg;
  logic                  fk_err_reg;

  logic [6:0]            fk_clamped;
  logic [11:0]           freq;
  logic [15:0]           word;
  logic [FRAME_BITS-1:0] frame;
  logic [1:0]            phase_next;
  logic [9:0]            tick_next;
  logic                  settle_done;

  // Frame contents are only meaningful in LOAD, where they are captured.
  assign fk_clamped = (bus.fk > 7'd78) ? 7'd78 : bus.fk;
  assign freq       = 12'd2402 + {5'd0, fk_clamped}
                    - (bus.rxmode ? {8'd0, bus.regi_IF_offset} : 12'd0);
  assign word       = {bus.regi_synth_addr, freq};
`ifdef RF_PROG_PARITY_EN
  // Odd parity: the extra bit makes the total count of ones odd.
  assign frame      = {word, ~^word};
`else
  assign frame      = word;
`endif

  // Bit phase 0-1 keeps sclk low, 2-3 high; wraps to the next bit after 3.
  assign phase_next  = phase_reg + 2'd1;
  // A tick in the current SETTLE cycle already counts toward the target.
  assign tick_next   = tick_reg + {9'd0, bus.p_033us};
  assign settle_done = (bus.regi_settle_time == 10'd0) ||
                       (tick_next == bus.regi_settle_time);

  // Request/serialise/settle sequencer with all bus outputs registered.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_reg  <= IDLE;
      pend_reg   <= 1'b0;
      shift_reg  <= '0;
      phase_reg  <= 2'd0;
      bit_reg    <= 5'd0;
      tick_reg   <= 10'd0;
      sen_n_reg  <= 1'b1;
      sclk_reg   <= 1'b0;
      sdata_reg  <= 1'b0;
      fkset_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      fk_err_reg <= 1'b0;
    end else begin
      fkset_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.fk_chg_p) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          fk_err_reg <= (bus.fk > 7'd78);
          shift_reg  <= frame;
          sdata_reg  <= frame[FRAME_BITS-1];
          sen_n_reg  <= 1'b0;
          sclk_reg   <= 1'b0;
          phase_reg  <= 2'd0;
          bit_reg    <= 5'd0;
          pend_reg   <= bus.fk_chg_p;
          state_reg  <= SHIFT;
        end
        SHIFT: begin
          phase_reg <= phase_next;
          sclk_reg  <= phase_next[1];
          if (bus.fk_chg_p) pend_reg <= 1'b1;
          if (phase_reg == 2'd3) begin
            if (bit_reg == LAST_BIT) begin
              sen_n_reg <= 1'b1;
              sdata_reg <= 1'b0;
              sclk_reg  <= 1'b0;
              if (pend_reg || bus.fk_chg_p) begin
                // Superseded channel: reload instead of settling.
                pend_reg  <= 1'b0;
                state_reg <= LOAD;
              end else begin
                tick_reg  <= 10'd0;
                state_reg <= SETTLE;
              end
            end else begin
              bit_reg   <= bit_reg + 5'd1;
              shift_reg <= shift_reg << 1;
              sdata_reg <= shift_reg[FRAME_BITS-2];
            end
          end
        end
        SETTLE: begin
          if (bus.fk_chg_p) begin
            // New request wins, even over a coincident fkset_p.
            state_reg <= LOAD;
          end else if (settle_done) begin
            fkset_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            tick_reg <= tick_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rf_sen_n = sen_n_reg;
  assign bus.rf_sclk  = sclk_reg;
  assign bus.rf_sdata = sdata_reg;
  assign bus.fkset_p  = fkset_reg;
  assign bus.busy     = busy_reg;
  assign bus.fk_err   = fk_err_reg;
endmodule

// File: tb/tb_rf_synth_prog.sv
// tb_rf_synth_prog: drives hop requests with randomized channels/registers,
// decodes the serial bus at the sclk rising edge and compares frames,
// frame timing and fkset_p timing against values computed from the
// channel-to-frequency rule and tick arithmetic.
module tb_rf_synth_prog;
`ifdef RF_PROG_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int SC = 4 * NB;

  logic clk  = 1'b0;
  logic rstz = 1'b1;
  int   cyc  = 0;
  int   tick_per = 0;
  int   checks = 0;
  int   errors = 0;

  int fall_q[$];
  int rise_q[$];
  int fkset_q[$];
  int word_q[$];
  int nbits_q[$];
  int cur_word = 0;
  int cur_n = 0;
  logic prev_sen = 1'b1;
  logic prev_sclk = 1'b0;

  rf_synth_prog_if bus();
  rf_synth_prog dut (.clk_6M(clk), .rstz(rstz), .bus(bus));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // p_033us is high during every cycle whose number is a multiple of tick_per
  initial begin
    bus.p_033us = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.p_033us = (tick_per > 0) && (cyc % tick_per == 0);
    end
  end

  // Bus monitor: records frame edges, decoded words and fkset_p cycles
  initial begin
    forever begin
      @(negedge clk);
      if (prev_sen === 1'b1 && bus.rf_sen_n === 1'b0) begin
        cur_word = 0; cur_n = 0; fall_q.push_back(cyc);
      end
      if (bus.rf_sen_n === 1'b0 && prev_sclk === 1'b0 && bus.rf_sclk === 1'b1) begin
        cur_word = (cur_word << 1) | int'(bus.rf_sdata); cur_n = cur_n + 1;
      end
      if (prev_sen === 1'b0 && bus.rf_sen_n === 1'b1) begin
        word_q.push_back(cur_word); nbits_q.push_back(cur_n); rise_q.push_back(cyc);
      end
      if (bus.fkset_p === 1'b1) fkset_q.push_back(cyc);
      prev_sen = bus.rf_sen_n;
      prev_sclk = bus.rf_sclk;
    end
  end

  function automatic int exp_word(input int f, input int rx, input int ifo, input int addr);
    int fc, fr, w;
    fc = (f > 78) ? 78 : f;
    fr = 2402 + fc - ((rx != 0) ? ifo : 0);
    w = addr * 4096 + fr;
    if (NB == 17) w = w * 2 + ((($countones(w) % 2) == 0) ? 1 : 0);
    return w;
  endfunction

  // fkset_p appears the cycle after the n-th tick counted from SETTLE entry
  function automatic int exp_fkset(input int entry, input int n, input int per);
    int k0;
    k0 = ((entry + per - 1) / per) * per;
    return k0 + (n - 1) * per + 1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_mon();
    fall_q.delete(); rise_q.delete(); fkset_q.delete(); word_q.delete(); nbits_q.delete();
  endtask

  task automatic set_regs(input int rx, input int ifo, input int addr, input int st, input int per);
    bus.rxmode = rx[0];
    bus.regi_IF_offset = 4'(ifo);
    bus.regi_synth_addr = 4'(addr);
    bus.regi_settle_time = 10'(st);
    tick_per = per;
  endtask

  task automatic req(input int f, output int t);
    bus.fk = 7'(f);
    bus.fk_chg_p = 1'b1;
    t = cyc;
    $display("req cyc=%0d fk=%0d rx=%0d if=%0d addr=%0d settle=%0d", cyc, f,
             bus.rxmode, bus.regi_IF_offset, bus.regi_synth_addr, bus.regi_settle_time);
    step();
    bus.fk_chg_p = 1'b0;
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    repeat (3) step();
    checks++; if (bus.rf_sen_n !== 1'b1) begin errors++; $display("FAIL rst_sen_n got %b want 1", bus.rf_sen_n); end
    checks++; if (bus.rf_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", bus.rf_sclk); end
    checks++; if (bus.rf_sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata got %b want 0", bus.rf_sdata); end
    checks++; if (bus.fkset_p !== 1'b0) begin errors++; $display("FAIL rst_fkset got %b want 0", bus.fkset_p); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.fk_err !== 1'b0) begin errors++; $display("FAIL rst_fk_err got %b want 0", bus.fk_err); end
    rstz = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int t, ent, ef, ew;
    clear_mon(); set_regs(0, 0, 5, 450, 18);
    req(0, t);
    ew = exp_word(0, 0, 0, 5);
    ent = t + 2 + SC;
    ef = exp_fkset(ent, 450, 18);
    goto(ent + 1);
    checks++; if (bus.rf_sdata !== 1'b0 || bus.rf_sen_n !== 1'b1) begin errors++; $display("FAIL basic_idle_bus got sdata=%b sen_n=%b want 0 1", bus.rf_sdata, bus.rf_sen_n); end
    goto(ef + 3);
    checks++; if (qget(word_q, 0) !== ew) begin errors++; $display("FAIL basic_word got %h want %h", qget(word_q, 0), ew); end
    checks++; if (qget(nbits_q, 0) !== NB) begin errors++; $display("FAIL basic_nbits got %0d want %0d", qget(nbits_q, 0), NB); end
    checks++; if (qget(fall_q, 0) !== t + 2) begin errors++; $display("FAIL basic_fall got %0d want %0d", qget(fall_q, 0), t + 2); end
    checks++; if (qget(rise_q, 0) !== ent) begin errors++; $display("FAIL basic_rise got %0d want %0d", qget(rise_q, 0), ent); end
    checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL basic_fkset got %0d want %0d", qget(fkset_q, 0), ef); end
    checks++; if (fkset_q.size() !== 1) begin errors++; $display("FAIL basic_fkset_cnt got %0d want 1", fkset_q.size()); end
    checks++; if (bus.fk_err !== 1'b0) begin errors++; $display("FAIL basic_fk_err got %b want 0", bus.fk_err); end
  endtask

  task automatic test_busy();
    int t, ef, bad;
    clear_mon(); set_regs(1, 2, 9, 10, 3);
    req(78, t);
    ef = exp_fkset(t + 2 + SC, 10, 3);
    bad = 0;
    for (int c = t + 1; c < ef; c++) begin
      goto(c);
      if (bus.busy !== 1'b1) bad++;
    end
    goto(ef + 2);
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_low_cycles got %0d want 0", bad); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", bus.busy); end
    checks++; if (qget(word_q, 0) !== exp_word(78, 1, 2, 9)) begin errors++; $display("FAIL busy_word got %h want %h", qget(word_q, 0), exp_word(78, 1, 2, 9)); end
    checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL busy_fkset got %0d want %0d", qget(fkset_q, 0), ef); end
  endtask

  task automatic test_clamp();
    int t, ef;
    clear_mon(); set_regs(0, 0, 1, 3, 2);
    req(100, t);
    ef = exp_fkset(t + 2 + SC, 3, 2);
    goto(ef + 2);
    checks++; if (qget(word_q, 0) !== exp_word(100, 0, 0, 1)) begin errors++; $display("FAIL clamp_word got %h want %h", qget(word_q, 0), exp_word(100, 0, 0, 1)); end
    checks++; if (bus.fk_err !== 1'b1) begin errors++; $display("FAIL clamp_fk_err got %b want 1", bus.fk_err); end
    req(10, t);
    ef = exp_fkset(t + 2 + SC, 3, 2);
    goto(ef + 2);
    checks++; if (qget(word_q, 1) !== exp_word(10, 0, 0, 1)) begin errors++; $display("FAIL clamp_word2 got %h want %h", qget(word_q, 1), exp_word(10, 0, 0, 1)); end
    checks++; if (bus.fk_err !== 1'b0) begin errors++; $display("FAIL clamp_fk_err_clear got %b want 0", bus.fk_err); end
  endtask

  task automatic test_random();
    int t, ef, f, rx, ifo, addr, st, per;
    for (int i = 0; i < 6; i++) begin
      f = $urandom_range(0, 127); rx = $urandom_range(0, 1); ifo = $urandom_range(0, 15);
      addr = $urandom_range(0, 15); st = $urandom_range(1, 20); per = $urandom_range(2, 6);
      clear_mon(); set_regs(rx, ifo, addr, st, per);
      req(f, t);
      ef = exp_fkset(t + 2 + SC, st, per);
      goto(ef + 2);
      checks++; if (qget(word_q, 0) !== exp_word(f, rx, ifo, addr)) begin errors++; $display("FAIL rand%0d_word got %h want %h", i, qget(word_q, 0), exp_word(f, rx, ifo, addr)); end
      checks++; if (qget(rise_q, 0) !== t + 2 + SC) begin errors++; $display("FAIL rand%0d_rise got %0d want %0d", i, qget(rise_q, 0), t + 2 + SC); end
      checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL rand%0d_fkset got %0d want %0d", i, qget(fkset_q, 0), ef); end
      checks++; if (bus.fk_err !== (f > 78)) begin errors++; $display("FAIL rand%0d_fk_err got %b want %b", i, bus.fk_err, (f > 78)); end
    end
  endtask

  task automatic test_supersede();
    int t, t2, f1, r1, ef;
    clear_mon(); set_regs(0, 0, 3, 5, 4);
    req(7, t);
    goto(t + 30);
    req(20, t2);
    f1 = t + 2 + SC + 1;
    r1 = f1 + SC;
    ef = exp_fkset(r1, 5, 4);
    goto(ef + 10);
    checks++; if (qget(word_q, 0) !== exp_word(7, 0, 0, 3)) begin errors++; $display("FAIL sup_word1 got %h want %h", qget(word_q, 0), exp_word(7, 0, 0, 3)); end
    checks++; if (qget(nbits_q, 0) !== NB) begin errors++; $display("FAIL sup_nbits1 got %0d want %0d", qget(nbits_q, 0), NB); end
    checks++; if (qget(word_q, 1) !== exp_word(20, 0, 0, 3)) begin errors++; $display("FAIL sup_word2 got %h want %h", qget(word_q, 1), exp_word(20, 0, 0, 3)); end
    checks++; if (qget(fall_q, 1) !== f1) begin errors++; $display("FAIL sup_fall2 got %0d want %0d", qget(fall_q, 1), f1); end
    checks++; if (fkset_q.size() !== 1 || qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL sup_fkset got n=%0d at %0d want n=1 at %0d", fkset_q.size(), qget(fkset_q, 0), ef); end
  endtask

  task automatic test_settle_abort();
    int t, t2, ef;
    clear_mon(); set_regs(0, 0, 6, 50, 4);
    req(11, t);
    goto(t + 2 + SC + 5);
    req(33, t2);
    ef = exp_fkset(t2 + 2 + SC, 50, 4);
    goto(ef + 2);
    checks++; if (qget(fall_q, 1) !== t2 + 2) begin errors++; $display("FAIL abort_fall2 got %0d want %0d", qget(fall_q, 1), t2 + 2); end
    checks++; if (qget(word_q, 1) !== exp_word(33, 0, 0, 6)) begin errors++; $display("FAIL abort_word2 got %h want %h", qget(word_q, 1), exp_word(33, 0, 0, 6)); end
    checks++; if (fkset_q.size() !== 1) begin errors++; $display("FAIL abort_fkset_cnt got %0d want 1", fkset_q.size()); end
    checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL abort_fkset got %0d want %0d", qget(fkset_q, 0), ef); end
  endtask

  task automatic test_coincident();
    int t, t2, e_old, ef;
    clear_mon(); set_regs(1, 7, 12, 4, 5);
    req(50, t);
    e_old = exp_fkset(t + 2 + SC, 4, 5);
    goto(e_old - 1);
    req(60, t2);
    ef = exp_fkset(t2 + 2 + SC, 4, 5);
    goto(ef + 2);
    checks++; if (qget(fall_q, 1) !== e_old + 1) begin errors++; $display("FAIL coin_fall2 got %0d want %0d", qget(fall_q, 1), e_old + 1); end
    checks++; if (qget(word_q, 1) !== exp_word(60, 1, 7, 12)) begin errors++; $display("FAIL coin_word2 got %h want %h", qget(word_q, 1), exp_word(60, 1, 7, 12)); end
    checks++; if (fkset_q.size() !== 1) begin errors++; $display("FAIL coin_fkset_cnt got %0d want 1", fkset_q.size()); end
    checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL coin_fkset got %0d want %0d", qget(fkset_q, 0), ef); end
  endtask

  task automatic test_reset_midframe();
    int t, t2, ef;
    clear_mon(); set_regs(0, 0, 2, 5, 3);
    req(25, t);
    goto(t + 40);
    rstz = 1'b0;
    #1;
    checks++; if (bus.rf_sen_n !== 1'b1) begin errors++; $display("FAIL rstmid_sen_n got %b want 1", bus.rf_sen_n); end
    checks++; if (bus.rf_sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b want 0", bus.rf_sclk); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    step(); step();
    rstz = 1'b1;
    clear_mon();
    repeat (200) step();
    checks++; if (fall_q.size() !== 0 || fkset_q.size() !== 0) begin errors++; $display("FAIL rstmid_resume got frames=%0d fkset=%0d want 0 0", fall_q.size(), fkset_q.size()); end
    req(26, t2);
    ef = exp_fkset(t2 + 2 + SC, 5, 3);
    goto(ef + 2);
    checks++; if (qget(word_q, 0) !== exp_word(26, 0, 0, 2)) begin errors++; $display("FAIL rstmid_word got %h want %h", qget(word_q, 0), exp_word(26, 0, 0, 2)); end
    checks++; if (qget(fkset_q, 0) !== ef) begin errors++; $display("FAIL rstmid_fkset got %0d want %0d", qget(fkset_q, 0), ef); end
  endtask

  initial begin
    bus.fk = 7'd0; bus.fk_chg_p = 1'b0;
    set_regs(0, 0, 0, 1, 0);
    #1;
    test_reset();
    test_basic();
    test_busy();
    test_clamp();
    test_random();
    test_supersede();
    test_settle_abort();
    test_coincident();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
